// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: register file geometry and the register address type.
package rv32i_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_sb.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush wipes; registered popcount.
module regfile_sb
    import rv32i_pkg::*;
#(
    parameter int NREGS = rv32i_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy_q,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_d;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int k = 0; k < NREGS; k++) begin
            n = n + {{AW{1'b0}}, v[k]};
        end
        return n;
    endfunction

    // A same-cycle issue beats the writeback clear: the newer producer is still in flight.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_valid && iss_rd == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (we && wa == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        cnt_d = popcount(busy_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with write-to-read bypass and busy scoreboard.
module regfile_mp_sb
    import rv32i_pkg::*;
#(
    parameter int XLEN   = rv32i_pkg::XLEN,
    parameter int NREGS  = rv32i_pkg::NREGS,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy_q;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < NREGS);
    endfunction

    regfile_sb #(
        .NREGS(NREGS),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy_q   (busy_q),
        .busy_cnt (busy_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (we && wa != '0 && in_range(wa)) begin
            mem_q[wa] <= wd;
        end
    end

    // Forwarding is gated by rst_n so reads stay zero while reset is held.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = rd_addr[i*AW +: AW];
        assign hit  = (BYPASS != 0) && rst_n && we && (wa == addr);

        always_comb begin
            rd_data[i*XLEN +: XLEN] = '0;
            rd_busy[i]              = 1'b0;
            if (addr != '0 && in_range(addr)) begin
                rd_data[i*XLEN +: XLEN] = hit ? wd : mem_q[addr];
                rd_busy[i]              = busy_q[addr] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a bypassing and a non-bypassing instance share all stimulus.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NREAD*AW-1:0]   rd_addr;
    logic                  we;
    logic [AW-1:0]         wa;
    logic [XLEN-1:0]       wd;
    logic                  iss_valid;
    logic [AW-1:0]         iss_rd;
    logic                  flush;

    logic [NREAD*XLEN-1:0] rd_data,  rd_data_nb;
    logic [NREAD-1:0]      rd_busy,  rd_busy_nb;
    logic [AW:0]           busy_cnt, busy_cnt_nb;

    int ntests = 0;
    int nfail  = 0;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rd_addr = {a2, a1, a0};
    endtask

    function automatic logic [31:0] port_data(input logic [NREAD*XLEN-1:0] d, input int i);
        return d[i*XLEN +: XLEN];
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        set_addr(5'd0, 5'd0, 5'd0);
        tick();
        tick();
        check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        rst_n = 1'b1;

        // Populate x5 and x7, then read them back.
        we = 1'b1; wa = 5'd5; wd = 32'h0000_AAAA;
        tick();
        wa = 5'd7; wd = 32'h0000_0777;
        tick();
        idle();
        set_addr(5'd5, 5'd7, 5'd0);
        #1;
        check("rd_x5", port_data(rd_data, 0), 32'h0000_AAAA);
        check("rd_x7", port_data(rd_data, 1), 32'h0000_0777);

        // Scoreboard: issue x3 at N, writeback at N+3.
        iss_valid = 1'b1; iss_rd = 5'd3;
        set_addr(5'd3, 5'd3, 5'd0);
        #1;
        check("sb_busy_same_cycle", 32'(rd_busy[0]), 32'd0);
        tick();
        idle();
        #1;
        check("sb_busy_n1", 32'(rd_busy[0]), 32'd1);
        check("sb_cnt_n1", 32'(busy_cnt), 32'd1);
        tick();
        tick();
        we = 1'b1; wa = 5'd3; wd = 32'h0000_0033;
        #1;
        check("sb_wb_busy_bypass", 32'(rd_busy[0]), 32'd0);
        check("sb_wb_busy_nobypass", 32'(rd_busy_nb[0]), 32'd1);
        check("sb_wb_data_nobypass", port_data(rd_data_nb, 0), 32'd0);
        tick();
        idle();
        #1;
        check("sb_cnt_n4", 32'(busy_cnt), 32'd0);
        check("sb_rd_x3", port_data(rd_data, 1), 32'h0000_0033);

        // Asynchronous reset mid-stream with a pending busy register and a live write.
        iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        idle();
        set_addr(5'd5, 5'd10, 5'd7);
        #1;
        check("pre_rst_cnt", 32'(busy_cnt), 32'd1);
        check("pre_rst_busy_x10", 32'(rd_busy[1]), 32'd1);
        we = 1'b1; wa = 5'd5; wd = 32'h5555_5555;
        rst_n = 1'b0;
        #1;
        check("rst_rd_x5", port_data(rd_data, 0), 32'd0);
        check("rst_rd_x7", port_data(rd_data, 2), 32'd0);
        check("rst_busy_x10", 32'(rd_busy[1]), 32'd0);
        check("rst_cnt", 32'(busy_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        check("post_rst_x5", port_data(rd_data, 0), 32'd0);
        check("post_rst_busy_x10", 32'(rd_busy[1]), 32'd0);

        // x0: write and issue are both discarded.
        we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        set_addr(5'd0, 5'd0, 5'd0);
        #1;
        check("x0_rd_same", port_data(rd_data, 0), 32'd0);
        check("x0_busy_same", 32'(rd_busy[0]), 32'd0);
        tick();
        idle();
        #1;
        check("x0_rd_after", port_data(rd_data, 0), 32'd0);
        check("x0_busy_after", 32'(rd_busy[0]), 32'd0);
        check("x0_cnt", 32'(busy_cnt), 32'd0);

        // Bypass: x7 holds the old value, same-cycle write forwards only with bypass enabled.
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0777;
        tick();
        wd = 32'h1234_5678;
        set_addr(5'd7, 5'd0, 5'd0);
        #1;
        check("byp_on", port_data(rd_data, 0), 32'h1234_5678);
        check("byp_off", port_data(rd_data_nb, 0), 32'h0000_0777);
        tick();
        idle();
        #1;
        check("byp_off_after", port_data(rd_data_nb, 0), 32'h1234_5678);

        // Set beats clear when issue and writeback hit x9 together.
        iss_valid = 1'b1; iss_rd = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'h0000_0099;
        tick();
        idle();
        set_addr(5'd9, 5'd0, 5'd0);
        #1;
        check("svc_busy", 32'(rd_busy[0]), 32'd1);
        check("svc_data", port_data(rd_data_nb, 0), 32'h0000_0099);
        check("svc_cnt", 32'(busy_cnt), 32'd1);
        we = 1'b1; wa = 5'd9; wd = 32'h0000_0999;
        tick();
        idle();
        #1;
        check("svc_clear_cnt", 32'(busy_cnt), 32'd0);

        // Flush: x1, x2, x4 busy; flush drops them, ignores issue of x6, still writes x2.
        iss_valid = 1'b1; iss_rd = 5'd1;
        tick();
        iss_rd = 5'd2;
        tick();
        iss_rd = 5'd4;
        tick();
        idle();
        set_addr(5'd1, 5'd2, 5'd4);
        #1;
        check("fl_pre_cnt", 32'(busy_cnt), 32'd3);
        check("fl_pre_busy", 32'(rd_busy), 32'b111);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
        we = 1'b1; wa = 5'd2; wd = 32'h0000_0022;
        tick();
        idle();
        #1;
        check("fl_cnt", 32'(busy_cnt), 32'd0);
        check("fl_busy", 32'(rd_busy), 32'b000);
        set_addr(5'd6, 5'd2, 5'd4);
        #1;
        check("fl_busy_x6", 32'(rd_busy[0]), 32'd0);
        check("fl_write_x2", port_data(rd_data, 1), 32'h0000_0022);
        we = 1'b1; wa = 5'd1; wd = 32'h0000_0011;
        tick();
        wa = 5'd4; wd = 32'h0000_0044;
        tick();
        idle();
        set_addr(5'd4, 5'd2, 5'd1);
        #1;
        check("p3_port0", port_data(rd_data, 0), 32'h0000_0044);
        check("p3_port1", port_data(rd_data, 1), 32'h0000_0022);
        check("p3_port2", port_data(rd_data, 2), 32'h0000_0011);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
